fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_RESET, default 64'h0000_0000_8000_0000, is the first fetch address after reset.
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  is an asynchronous, active-low reset.
REQ-004 Port ireq_valid  output  1  is the instruction-bus request valid.
REQ-005 Port ireq_addr  output  64  is the instruction-bus request address; bits [1:0] are always 0.
REQ-006 Port iresp_ok  input  1  signals that the current request completed this cycle; it is only sampled while ireq_valid=1.
REQ-007 Port iresp_data  input  32  is the instruction word, valid when iresp_ok=1.
REQ-008 Port out_valid  output  1  means the fetched instruction is presented to decode.
REQ-009 Port out_ready  input  1  means decode accepts the instruction this cycle.
REQ-010 Port out_pc  output  64  is the PC of the presented instruction.
REQ-011 Port out_instr  output  32  is the presented instruction word; it is the u32 consumed by the decoder.
REQ-012 Port redirect_valid  input  1  is a redirect from branch/jump resolution.
REQ-013 Port redirect_pc  output-side target  input  64  is the redirect target; bits [1:0] are ignored and treated as 0.

Function
REQ-014 The block SHALL hold internal registers pc (next fetch address), req_pc (in-flight address), out buffer {out_valid, out_pc, out_instr}, pending buffer {pend_pc, pend_instr}, and a state register with states REQ, WAIT_OUT, DROP.
REQ-015 In REQ, ireq_valid SHALL be 1 and ireq_addr SHALL equal req_pc; req_pc is loaded from pc on entry to REQ and stays stable until iresp_ok.
REQ-016 In REQ with iresp_ok=1, no redirect, and the out buffer free (out_valid=0 or out_ready=1), the block SHALL load the out buffer with {1, req_pc, iresp_data}, set pc and req_pc to req_pc+4, and stay in REQ, giving back-to-back throughput of one instruction per response.
REQ-017 In REQ with iresp_ok=1, no redirect, and the out buffer held (out_valid=1, out_ready=0), the block SHALL store {req_pc, iresp_data} in the pending buffer, set pc to req_pc+4, and go to WAIT_OUT.
REQ-018 In WAIT_OUT, ireq_valid SHALL be 0; when out_ready=1, the out buffer SHALL load from the pending buffer, req_pc SHALL load pc, and the state SHALL go to REQ.
REQ-019 When out_valid=1, out_ready=1, and no new data is loaded, out_valid SHALL clear the next cycle.
REQ-020 out_pc and out_instr SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 redirect_valid=1 SHALL, in the next cycle: clear out_valid, discard the pending buffer, and set pc to {redirect_pc[63:2], 2'b00}.
REQ-022 If redirect_valid=1 occurs in REQ together with iresp_ok=1, the response SHALL be dropped, req_pc SHALL be set to the redirect target, and the state SHALL stay in REQ.
REQ-023 If redirect_valid=1 occurs in REQ without iresp_ok, the state SHALL go to DROP, and req_pc SHALL keep its old value because the bus request stays stable.
REQ-024 If redirect_valid=1 occurs in WAIT_OUT, req_pc SHALL be set to the redirect target and the state SHALL go to REQ.
REQ-025 In DROP, ireq_valid SHALL be 1 with ireq_addr=req_pc; on iresp_ok, the data SHALL be discarded, req_pc SHALL load pc, and the state SHALL go to REQ.
REQ-026 A redirect in DROP SHALL only update pc, and the state SHALL stay in DROP.
REQ-027 Redirect SHALL take priority over every other event in the same cycle; an out handshake in a redirect cycle is complete and not replayed.
REQ-028 PC arithmetic SHALL be 64-bit modulo 2^64: 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
REQ-029 Latency from redirect_valid to ireq_addr=target SHALL be 1 cycle when no request is in flight (REQ with iresp_ok, or WAIT_OUT).

Reset
REQ-030 While reset=0, regardless of clk, the block SHALL force state=REQ, pc=req_pc=PC_RESET, and clear out_valid, out_pc, out_instr, pend_pc, and pend_instr.
REQ-031 The first cycle after reset release SHALL present ireq_valid=1 with ireq_addr=PC_RESET.
REQ-032 Reset asserted mid-request SHALL abandon the request; the instruction bus is reset by the same signal.

Verification
REQ-033 Reset release, out_ready=1, iresp_ok every cycle with data 0x00000013 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, each with out_instr 0x00000013.
REQ-034 out_ready=0 while two responses arrive -> WAIT_OUT is entered, ireq_valid=0, and out_pc=0x80000000 is held; raise out_ready -> out_pc=0x80000004, then fetch resumes at 0x80000008.
REQ-035 Redirect to 0x80001000 one cycle before iresp_ok -> DROP is entered, ireq_addr stays at the old address until iresp_ok, that data never appears on out, and the next ireq_addr is 0x80001000.
REQ-036 Redirect to 0x80002003 in the same cycle as iresp_ok in REQ -> out_valid=0 next cycle and ireq_addr=0x80002000.
REQ-037 Redirect in WAIT_OUT -> the pending instruction is never presented and the next request goes to the target.
REQ-038 Reset asserted asynchronously mid-DROP -> out_valid=0 immediately, and after release ireq_addr=0x80000000.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
//==============================================================================
// fetch_stage: sequential instruction fetch with one-entry pending buffer,
// decode back-pressure and branch/jump redirect handling.  Revision: 1.0
//==============================================================================
module fetch_stage #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam logic [1:0]  c_REQ      = 2'd0;
    localparam logic [1:0]  c_WAIT_OUT = 2'd1;
    localparam logic [1:0]  c_DROP     = 2'd2;
    localparam logic [63:0] c_PC_BASE  = PC_RESET & ~64'd3;

    logic [1:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] req_pc_q, req_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [63:0] pend_pc_q, pend_pc_d;
    logic [31:0] pend_instr_q, pend_instr_d;

    logic [63:0] w_redir_tgt;
    logic [63:0] w_req_pc_inc;
    logic        w_out_free;

    assign w_redir_tgt  = redirect_pc & ~64'd3;
    assign w_req_pc_inc = req_pc_q + 64'd4;
    assign w_out_free   = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= c_REQ;
            pc_q         <= c_PC_BASE;
            req_pc_q     <= c_PC_BASE;
            out_valid_q  <= 1'b0;
            out_pc_q     <= 64'd0;
            out_instr_q  <= 32'd0;
            pend_pc_q    <= 64'd0;
            pend_instr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            pend_pc_q    <= pend_pc_d;
            pend_instr_q <= pend_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        pend_pc_d    = pend_pc_q;
        pend_instr_d = pend_instr_q;
        if (redirect_valid) begin
            out_valid_d = 1'b0;
            pc_d        = w_redir_tgt;
            case (state_q)
                c_REQ: begin
                    // An outstanding request cannot be withdrawn; let it finish in DROP.
                    if (iresp_ok) req_pc_d = w_redir_tgt;
                    else          state_d  = c_DROP;
                end
                c_WAIT_OUT: begin
                    req_pc_d = w_redir_tgt;
                    state_d  = c_REQ;
                end
                c_DROP:  ;
                default: state_d = c_REQ;
            endcase
        end else begin
            case (state_q)
                c_REQ: begin
                    if (iresp_ok) begin
                        pc_d = w_req_pc_inc;
                        if (w_out_free) begin
                            out_valid_d = 1'b1;
                            out_pc_d    = req_pc_q;
                            out_instr_d = iresp_data;
                            req_pc_d    = w_req_pc_inc;
                        end else begin
                            pend_pc_d    = req_pc_q;
                            pend_instr_d = iresp_data;
                            state_d      = c_WAIT_OUT;
                        end
                    end
                end
                c_WAIT_OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b1;
                        out_pc_d    = pend_pc_q;
                        out_instr_d = pend_instr_q;
                        req_pc_d    = pc_q;
                        state_d     = c_REQ;
                    end
                end
                c_DROP: begin
                    if (iresp_ok) begin
                        req_pc_d = pc_q;
                        state_d  = c_REQ;
                    end
                end
                default: state_d = c_REQ;
            endcase
        end
    end

    always_comb begin
        ireq_valid = (state_q == c_REQ) || (state_q == c_DROP);
        ireq_addr  = req_pc_q & ~64'd3;
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

endmodule
`default_nettype wire
